// File: rtl/oh_pipe_elastic.sv
// rtl/oh_pipe_elastic.sv - DW-wide DEPTH-stage elastic retiming pipeline with valid/ready flow control
module oh_pipe_elastic #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush,
  input  logic          valid_in,
  input  logic [DW-1:0] in,
  output logic          ready_in,
  output logic          valid_out,
  output logic [DW-1:0] out,
  input  logic          ready_out,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] ld;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             chain;

  // A stage may load when it is empty or the stage after it is moving;
  // the temporary keeps the OR chain free of self-referencing vector bits.
  always_comb begin
    ld    = '0;
    chain = ~v_q[DEPTH-1] | ready_out;
    ld[DEPTH-1] = chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain = ~v_q[i] | chain;
      ld[i] = chain;
    end
  end

  assign ready_in = ld[0] & ~flush;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end

    if (ld[0]) begin
      v_d[0] = valid_in;
      if (valid_in && !flush) begin
        d_d[0] = in;
      end
    end

    // Bubbles advance their valid bit but never overwrite held data.
    for (int i = 1; i < DEPTH; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1] && !flush) begin
          d_d[i] = d_q[i-1];
        end
      end
    end

    if (flush) begin
      v_d = '0;
    end

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign valid_out = v_q[DEPTH-1];
  assign out       = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_oh_pipe_elastic.sv
// tb/tb_oh_pipe_elastic.sv - directed bench for oh_pipe_elastic with DW=8, DEPTH=3
module tb_oh_pipe_elastic;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          nreset;
  logic          flush;
  logic          valid_in;
  logic [DW-1:0] in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] out;
  logic          ready_out;
  logic [CW-1:0] count;

  int vectors = 0;
  int errors  = 0;

  oh_pipe_elastic #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (flush),
    .valid_in  (valid_in),
    .in        (in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .out       (out),
    .ready_out (ready_out),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic vo, input logic [7:0] o, input logic [1:0] c);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
    chk({tag, ".out"},       32'(out),       32'(o));
    chk({tag, ".count"},     32'(count),     32'(c));
  endtask

  task automatic fill3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    in = a; tick();
    in = b; tick();
    in = c; tick();
    valid_in = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; flush = 1'b0; valid_in = 1'b0; in = '0; ready_out = 1'b0;
    #3;
    chk_state("rst0", 1'b0, 8'h00, 2'd0);
    chk("rst0.ready_in", 32'(ready_in), 32'd1);
    tick(); tick();
    nreset = 1'b1;

    // Streaming: value k enters at edge k and reaches out at edge k+2
    ready_out = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      valid_in = 1'b1; in = 8'(k);
      #1 chk($sformatf("stream%0d.ready_in", k), 32'(ready_in), 32'd1);
      tick();
      if (k >= 3) chk_state($sformatf("stream%0d", k), 1'b1, 8'(k - 2), 2'd3);
    end
    valid_in = 1'b0;
    tick(); chk_state("drain1", 1'b1, 8'h07, 2'd2);
    tick(); chk_state("drain2", 1'b1, 8'h08, 2'd1);
    tick(); chk_state("drain3", 1'b0, 8'h08, 2'd0);
    ready_out = 1'b0;
    #1 chk("empty.ready_in", 32'(ready_in), 32'd1);

    // Stall and fill
    fill3(8'hA0, 8'hA1, 8'hA2);
    chk_state("full", 1'b1, 8'hA0, 2'd3);
    valid_in = 1'b1; in = 8'hA3;
    #1 chk("full.ready_in", 32'(ready_in), 32'd0);
    tick(); chk_state("stall", 1'b1, 8'hA0, 2'd3);
    ready_out = 1'b1;
    #1 chk("release.ready_in", 32'(ready_in), 32'd1);
    tick(); chk_state("rel1", 1'b1, 8'hA1, 2'd3);
    valid_in = 1'b0;
    tick(); chk_state("rel2", 1'b1, 8'hA2, 2'd2);
    tick(); chk_state("rel3", 1'b1, 8'hA3, 2'd1);
    tick(); chk_state("rel4", 1'b0, 8'hA3, 2'd0);

    // Bubble collapse
    ready_out = 1'b0;
    valid_in = 1'b1; in = 8'h10; tick();
    valid_in = 1'b0; tick();
    valid_in = 1'b1; in = 8'h11; tick();
    valid_in = 1'b0; tick();
    chk_state("bubble", 1'b1, 8'h10, 2'd2);
    ready_out = 1'b1;
    tick(); chk_state("bub1", 1'b1, 8'h11, 2'd1);
    tick(); chk_state("bub2", 1'b0, 8'h11, 2'd0);

    // Flush
    fill3(8'hC0, 8'hC1, 8'hC2);
    chk_state("prefl", 1'b1, 8'hC0, 2'd3);
    flush = 1'b1; valid_in = 1'b1; in = 8'h55;
    #1 chk("flush.ready_in", 32'(ready_in), 32'd0);
    tick();
    flush = 1'b0; valid_in = 1'b0;
    chk_state("postfl", 1'b0, 8'hC0, 2'd0);
    ready_out = 1'b1;
    tick(); tick(); tick();
    chk_state("nofl55", 1'b0, 8'hC0, 2'd0);

    // Simultaneous accept/emit when full
    fill3(8'hD0, 8'hD1, 8'hD2);
    ready_out = 1'b1; valid_in = 1'b1; in = 8'h77;
    #1 chk("fullthru.ready_in", 32'(ready_in), 32'd1);
    tick(); chk_state("sim1", 1'b1, 8'hD1, 2'd3);
    valid_in = 1'b0;
    tick(); chk_state("sim2", 1'b1, 8'hD2, 2'd2);
    tick(); chk_state("sim3", 1'b1, 8'h77, 2'd1);
    tick(); chk_state("sim4", 1'b0, 8'h77, 2'd0);

    // Asynchronous reset mid-stream with every stage valid
    valid_in = 1'b1;
    in = 8'hE1; tick();
    in = 8'hE2; tick();
    in = 8'hE3; tick();
    chk_state("prerst", 1'b1, 8'hE1, 2'd3);
    ready_out = 1'b0;
    #2 nreset = 1'b0;
    #1;
    chk_state("midrst", 1'b0, 8'h00, 2'd0);
    chk("midrst.ready_in", 32'(ready_in), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/oh_pipe_elastic.md
Name: oh_pipe_elastic

Overview:
- Parametrised successor to the single-bit-wide level latch.
- DW-wide, DEPTH-stage edge-triggered retiming pipeline with per-stage valid bits, ready/valid backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Placed on long inter-block routes to retime data while preserving flow control.
- Data registers hold their value when not loaded, mirroring the latch's hold behaviour, but are flop-based and clocked on the rising edge.

Parameters:
- DW, 8: data width in bits (>=1).
- DEPTH, 2: number of pipeline stages (>=1).
- CW, $clog2(DEPTH+1): count output width (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- nreset  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- valid_in  input  1  upstream data valid.
- in  input  DW  upstream data.
- ready_in  output  1  pipeline accepts in when valid_in & ready_in.
- valid_out  output  1  output stage holds valid data.
- out  output  DW  output data (stage DEPTH-1).
- ready_out  input  1  downstream accepts out when valid_out & ready_out.
- count  output  CW  number of valid stages, 0..DEPTH.

Behaviour:
- Reset is asynchronous, active-low, on nreset=0. It clears all stage valids v[0..DEPTH-1] and data d[0..DEPTH-1]. After reset: valid_out=0, out=0, count=0, ready_in=1 (combinational).
- Load enables are combinational, computed from the output end backward:
  - ld[DEPTH-1] = ~v[DEPTH-1] | ready_out.
  - ld[i] = ~v[i] | ld[i+1] for i < DEPTH-1.
  - ready_in = ld[0] & ~flush.
- Stage update on clk rising edge when ld[i]=1:
  - v[0] <= valid_in; v[i] <= v[i-1].
  - d[i] is written only when the incoming valid is 1 (valid_in for stage 0, v[i-1] otherwise).
  - Otherwise d[i] holds. Bubbles never overwrite data.
- When ld[i]=0, v[i] and d[i] hold (stall).
- Bubble collapse: an empty stage always loads, so gaps close while the output is stalled. DEPTH items can be buffered.
- Latency: DEPTH cycles from an accepted input to valid_out when unstalled. Throughput is 1 transfer/cycle.
- Full: when all v=1 and ready_out=0, ready_in=0. When all v=1 and ready_out=1, ready_in=1 and a simultaneous accept plus emit occurs. count is unchanged.
- Empty: when all v=0, valid_out=0, out holds its last value, and ready_in=1 regardless of ready_out.
- Flush (synchronous):
  - Next edge: all v <= 0, count <= 0. Data holds.
  - During the flush cycle ready_in=0, so valid_in is ignored, not accepted.
  - A downstream transfer in the flush cycle (valid_out & ready_out) still counts as delivered.
- count is registered: count <= popcount of the next-state v. It equals the number of v bits set and never exceeds DEPTH.
- Reset mid-operation: all in-flight data is discarded immediately (asynchronously). The outputs above take their reset values without waiting for a clock.
- valid_out = v[DEPTH-1]; out = d[DEPTH-1]. Both are direct register outputs with no combinational path from in.
- ready_in has a combinational path from ready_out through a DEPTH-deep OR chain. This is intended.
- DEPTH=1 degenerates to a single registered stage with pass-through ready.

Test Plan:
- Reset, DW=8, DEPTH=3: hold nreset=0 mid-stream with v all 1 -> immediately valid_out=0, out=0x00, count=0, ready_in=1.
- Streaming: ready_out=1, drive in=0x01,0x02,0x03,... on consecutive cycles with valid_in=1 -> out=0x01 three cycles after acceptance, then one value per cycle; count steady at 3.
- Stall and fill: ready_out=0, send 0xA0, 0xA1, 0xA2, 0xA3 -> first three accepted, count=3, ready_in=0 while 0xA3 is held. Set ready_out=1 -> out sequence A0, A1, A2, A3, with no loss or duplication.
- Bubble collapse: send 0x10, one idle cycle, 0x11 with ready_out=0 -> both collapse into stages 2 and 1, count=2. Release -> 0x10 then 0x11 on consecutive cycles.
- Flush: with count=3 and ready_out=0, assert flush for one cycle with valid_in=1, in=0x55 -> ready_in=0 that cycle. Next cycle: count=0, valid_out=0, and 0x55 never appears at out.
- Simultaneous full accept/emit: full with ready_out=1 and valid_in=1 carrying 0x77 -> count stays 3 and 0x77 emerges 3 transfers later.
